dmem_responder: RTL and testbench

Data-memory responder on the CPU core's data port: receives the core's address, write data and write strobe, and returns read data. Decodes a word-addressed RAM region and a small MMIO region (GPIO output register and a 32-bit compare timer with interrupt). Sits between the core's data port and the SoC's on-chip storage and peripherals.

---
 rtl/dmem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-cycle data-port responder for the CPU core.
// Serves a word-addressed RAM region at address 0 and a small MMIO page
// (GPIO output register plus a 32-bit compare timer with interrupt).
// Every cycle performs a read of dmem_addr, so rdata is always registered
// one cycle after the address. Reads are read-first with respect to a
// same-cycle write.

module dmem_responder #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_we,
    output logic [31:0] dmem_rdata,
    output logic [7:0]  gpio_out,
    output logic        timer_irq,
    output logic        bus_err
);

    // RAM word-index width; MEM_WORDS is a power of two.
    localparam int unsigned AW = $clog2(MEM_WORDS);

    // MMIO register word offsets within the 4 KB MMIO page.
    localparam logic [9:0] OFF_GPIO   = 10'd0;
    localparam logic [9:0] OFF_COUNT  = 10'd1;
    localparam logic [9:0] OFF_CMP    = 10'd2;
    localparam logic [9:0] OFF_CTRL   = 10'd3;
    localparam logic [9:0] OFF_STATUS = 10'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] ram_q [MEM_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic [7:0]  gpio_q;
    logic [7:0]  gpio_d;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic [31:0] cmp_q;
    logic [31:0] cmp_d;
    logic [1:0]  ctrl_q;
    logic [1:0]  ctrl_d;
    logic        pend_q;
    logic        pend_d;
    logic        irq_q;
    logic        irq_d;
    logic        berr_q;
    logic        berr_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [AW-1:0]        word_idx;
    logic                 ram_hit;
    logic                 mmio_page;
    logic [9:0]           reg_off;
    logic                 sel_gpio;
    logic                 sel_count;
    logic                 sel_cmp;
    logic                 sel_ctrl;
    logic                 sel_status;
    logic                 unmapped;
    logic                 ram_we;
    logic [MEM_WORDS-1:0] word_we;
    logic [1:0]           unused_addr_lsbs;

    // Byte-lane bits are meaningless: every access is a full word.
    assign unused_addr_lsbs = dmem_addr[1:0];

    assign word_idx   = dmem_addr[AW+1:2];
    assign ram_hit    = (dmem_addr[31:AW+2] == '0);
    assign mmio_page  = (dmem_addr[31:12] == MMIO_BASE[31:12]);
    assign reg_off    = dmem_addr[11:2];
    assign sel_gpio   = mmio_page && (reg_off == OFF_GPIO);
    assign sel_count  = mmio_page && (reg_off == OFF_COUNT);
    assign sel_cmp    = mmio_page && (reg_off == OFF_CMP);
    assign sel_ctrl   = mmio_page && (reg_off == OFF_CTRL);
    assign sel_status = mmio_page && (reg_off == OFF_STATUS);
    assign unmapped   = !ram_hit && !sel_gpio && !sel_count && !sel_cmp
                        && !sel_ctrl && !sel_status;
    assign ram_we     = dmem_we && ram_hit;

    // One write-enable per RAM word, decoded from the word index.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_WORDS; gi++) begin : g_word_we
            assign word_we[gi] = ram_we && (word_idx == AW'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read mux: always reflects pre-edge state, which gives read-first
    // behaviour and returns COUNT before this edge's increment.
    // ------------------------------------------------------------------
    always_comb begin
        rdata_d = 32'h0;
        if (ram_hit) begin
            rdata_d = ram_q[word_idx];
        end else if (sel_gpio) begin
            rdata_d = {24'h0, gpio_q};
        end else if (sel_count) begin
            rdata_d = count_q;
        end else if (sel_cmp) begin
            rdata_d = cmp_q;
        end else if (sel_ctrl) begin
            rdata_d = {30'h0, ctrl_q};
        end else if (sel_status) begin
            rdata_d = {31'h0, pend_q};
        end
    end

    // ------------------------------------------------------------------
    // Register and timer next-state logic
    // ------------------------------------------------------------------
    logic timer_en;
    logic cmp_hit;
    logic status_clr;

    assign timer_en   = ctrl_q[0];
    // Compare uses the pre-write, pre-increment COUNT.
    assign cmp_hit    = timer_en && (count_q == cmp_q);
    assign status_clr = dmem_we && sel_status && dmem_wdata[0];

    // Next-state for MMIO registers, timer, interrupt and bus error.
    always_comb begin
        gpio_d  = gpio_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        count_d = count_q;
        if (dmem_we && sel_gpio) begin
            gpio_d = dmem_wdata[7:0];
        end
        if (dmem_we && sel_cmp) begin
            cmp_d = dmem_wdata;
        end
        if (dmem_we && sel_ctrl) begin
            ctrl_d = dmem_wdata[1:0];
        end
        // A software write to COUNT overrides the free-running increment.
        if (dmem_we && sel_count) begin
            count_d = dmem_wdata;
        end else if (timer_en) begin
            count_d = count_q + 32'd1;
        end
        // A compare event on the same edge as a clear keeps pending set.
        pend_d = cmp_hit || (pend_q && !status_clr);
        // Interrupt follows the post-edge pending/enable state.
        irq_d  = pend_d && ctrl_d[1];
        berr_d = unmapped;
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // RAM flop array: cleared on reset, one word written per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) begin
                ram_q[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < int'(MEM_WORDS); i++) begin
                if (word_we[i]) begin
                    ram_q[i] <= dmem_wdata;
                end
            end
        end
    end

    // Registered read data, MMIO registers, timer and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 32'h0;
            gpio_q  <= 8'h0;
            count_q <= 32'h0;
            cmp_q   <= 32'h0;
            ctrl_q  <= 2'b00;
            pend_q  <= 1'b0;
            irq_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            gpio_q  <= gpio_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            berr_q  <= berr_d;
        end
    end

    assign dmem_rdata = rdata_q;
    assign gpio_out   = gpio_q;
    assign timer_irq  = irq_q;
    assign bus_err    = berr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed stimulus pushes expected
// read data / bus error into a scoreboard; a negedge monitor pops and compares.

module tb_dmem_responder;

    localparam logic [31:0] MMIO = 32'h0000_1000;
    localparam logic [31:0] A_GPIO   = MMIO + 32'h00;
    localparam logic [31:0] A_COUNT  = MMIO + 32'h04;
    localparam logic [31:0] A_CMP    = MMIO + 32'h08;
    localparam logic [31:0] A_CTRL   = MMIO + 32'h0C;
    localparam logic [31:0] A_STATUS = MMIO + 32'h10;

    logic        clk;
    logic        reset_n;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic [7:0]  gpio_out;
    logic        timer_irq;
    logic        bus_err;

    dmem_responder #(
        .MEM_WORDS(256),
        .MMIO_BASE(MMIO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_we   (dmem_we),
        .dmem_rdata(dmem_rdata),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq),
        .bus_err   (bus_err)
    );

    typedef struct {
        int          tcyc;
        logic [31:0] addr;
        bit          chk;
        logic [31:0] exp_rd;
        logic        exp_err;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Address map model: RAM 0..0x3FF, MMIO registers at offsets 0x00..0x10.
    function automatic logic is_unmapped(input logic [31:0] a);
        if (a < 32'd1024) return 1'b0;
        if (a >= MMIO && a < MMIO + 32'h14) return 1'b0;
        return 1'b1;
    endfunction

    // Present one access for one cycle; expected result appears after the edge.
    task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input bit chk, input logic [31:0] exp);
        exp_t e;
        dmem_addr  = a;
        dmem_we    = we;
        dmem_wdata = wd;
        e.tcyc    = cyc + 1;
        e.addr    = a;
        e.chk     = chk;
        e.exp_rd  = exp;
        e.exp_err = is_unmapped(a);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        issue(a, 1'b0, 32'h0, 1'b1, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        issue(a, 1'b1, wd, 1'b0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Monitor: compare each scheduled response on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].tcyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            $display("txn cyc=%0d addr=%h rdata=%h bus_err=%b", cyc, e.addr, dmem_rdata, bus_err);
            if (e.tcyc != cyc) check("sb_timing", 32'(cyc), 32'(e.tcyc));
            if (e.chk) check("rdata", dmem_rdata, e.exp_rd);
            check("bus_err", {31'h0, bus_err}, {31'h0, e.exp_err});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc        = 0;
        n_checks   = 0;
        n_pass     = 0;
        reset_n    = 1'b0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        dmem_we    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_rdata", dmem_rdata, 32'h0);
        check("rst_gpio", {24'h0, gpio_out}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        check("rst_berr", {31'h0, bus_err}, 32'h0);
        rd(32'h0, 32'h0);

        // RAM write/read, byte-lane bits ignored
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, 32'hDEAD_BEEF);
        rd(32'h13, 32'hDEAD_BEEF);

        // Read-first on same-cycle write
        wr(32'h20, 32'h5);
        issue(32'h20, 1'b1, 32'h1234, 1'b1, 32'h5);
        rd(32'h20, 32'h1234);

        // GPIO
        wr(A_GPIO, 32'h1A5);
        check("gpio_out", {24'h0, gpio_out}, 32'hA5);
        rd(A_GPIO, 32'hA5);

        // Timer: CMP=10, COUNT=0, then enable with irq
        wr(A_CMP, 32'd10);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'd3);
        idle(10);
        check("irq_before_match", {31'h0, timer_irq}, 32'h0);
        idle(1);
        check("irq_at_match", {31'h0, timer_irq}, 32'h1);
        rd(A_STATUS, 32'h1);
        rd(A_COUNT, 32'd12);
        wr(A_STATUS, 32'h0);
        check("irq_w0_no_clear", {31'h0, timer_irq}, 32'h1);
        wr(A_STATUS, 32'h1);
        check("irq_w1c", {31'h0, timer_irq}, 32'h0);
        rd(A_STATUS, 32'h0);

        // Set beats clear on the same edge
        wr(A_COUNT, 32'd100);
        wr(A_CMP, 32'd101);
        wr(A_STATUS, 32'h1);
        check("irq_set_wins", {31'h0, timer_irq}, 32'h1);
        rd(A_STATUS, 32'h1);

        // Wrap
        wr(A_COUNT, 32'hFFFF_FFFF);
        rd(A_COUNT, 32'hFFFF_FFFF);
        rd(A_COUNT, 32'h0);

        // Unmapped accesses
        rd(MMIO + 32'h20, 32'h0);
        rd(A_GPIO, 32'hA5);
        wr(MMIO + 32'h20, 32'hFFFF_FFFF);
        rd(A_GPIO, 32'hA5);
        rd(A_CMP, 32'd101);
        rd(A_CTRL, 32'd3);
        rd(32'h20, 32'h1234);
        rd(MMIO + 32'h14, 32'h0);
        rd(32'h0000_0400, 32'h0);
        rd(32'h0, 32'h0);
        check("gpio_after_unmapped", {24'h0, gpio_out}, 32'hA5);

        // Drain scoreboard before an asynchronous reset
        @(negedge clk);
        @(posedge clk);
        #1;

        // Reset mid-operation with a write in flight
        dmem_addr  = 32'h30;
        dmem_wdata = 32'hCAFE_F00D;
        dmem_we    = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_rdata", dmem_rdata, 32'h0);
        check("midrst_gpio", {24'h0, gpio_out}, 32'h0);
        check("midrst_irq", {31'h0, timer_irq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        dmem_we   = 1'b0;
        dmem_addr = 32'h0;
        @(posedge clk);
        #1;
        rd(32'h30, 32'h0);
        rd(32'h10, 32'h0);
        rd(A_CTRL, 32'h0);
        rd(A_COUNT, 32'h0);
        rd(A_GPIO, 32'h0);

        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
